spi_ip_xfer_ctrl: RTL and testbench

SPI master transfer sequencer. Owns one transfer from start to done: latches the word and mode, and enables and configures the shared clock divider. It consumes the divider's time-base tick, generates SCK/SS_n per CPOL/CPHA, and shifts MOSI while sampling MISO. It sits between the register/FIFO front-end (start/busy/done handshake) and the divider plus SPI pins.

---
 rtl/spi_ip_pkg.sv | 26 ++
 rtl/spi_ip_shift_reg.sv | 38 +++
 rtl/spi_ip_xfer_ctrl.sv | 151 +++++++++++++++
 tb/tb_spi_ip_xfer_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ip_pkg.sv
// Shared definitions for the SPI master IP: transfer FSM encoding,
// mode-bit positions and the width helper used for parameter defaults.
package spi_ip_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } xfer_state_e;

    localparam int MODE_CPOL_BIT = 1;
    localparam int MODE_CPHA_BIT = 0;

    // Bits needed to index 'value' distinct settings; never returns less than 1.
    function automatic int clogb2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_ip_shift_reg.sv
// Transmit/receive shift registers for one SPI word; bit order is chosen
// by lsb_first, serial-out is the current head bit of the transmit word.
module spi_ip_shift_reg
    import spi_ip_pkg::*;
#(
    parameter int PARAM_DATA_WIDTH = 8
) (
    input  logic                        clk_i,
    input  logic                        load_i,
    input  logic [PARAM_DATA_WIDTH-1:0] load_val_i,
    input  logic                        lsb_first_i,
    input  logic                        shift_i,
    input  logic                        sample_i,
    input  logic                        sin_i,
    output logic                        sout_o,
    output logic [PARAM_DATA_WIDTH-1:0] rx_o
);
    localparam int DW = PARAM_DATA_WIDTH;

    logic [DW-1:0] tx_q;
    logic [DW-1:0] rx_q;

    always_ff @(posedge clk_i) begin
        if (load_i) begin
            tx_q <= load_val_i;
        end else if (shift_i) begin
            tx_q <= lsb_first_i ? (tx_q >> 1) : (tx_q << 1);
        end
        // Received bits enter at the far end so the first bit lands in its final position.
        if (sample_i) begin
            rx_q <= lsb_first_i ? {sin_i, rx_q[DW-1:1]} : {rx_q[DW-2:0], sin_i};
        end
    end

    assign sout_o = lsb_first_i ? tx_q[0] : tx_q[DW-1];
    assign rx_o   = rx_q;

endmodule

// File: rtl/spi_ip_xfer_ctrl.sv
// SPI master transfer sequencer: owns one word from accept to done, drives
// SCK/SS_n/MOSI from the external divider tick and samples MISO.
module spi_ip_xfer_ctrl
    import spi_ip_pkg::*;
#(
    parameter int PARAM_DATA_WIDTH = 8,
    parameter int PARAM_MAX_DIV    = 8,
    parameter int PARAM_DIV_W      = clogb2(PARAM_MAX_DIV)
) (
    input  logic                        xfer_clk_i,
    input  logic                        xfer_rst_i,
    input  logic                        xfer_start_i,
    input  logic                        xfer_cpol_i,
    input  logic                        xfer_cpha_i,
    input  logic                        xfer_lsb_first_i,
    input  logic [PARAM_DIV_W-1:0]      xfer_clk_div_i,
    input  logic [PARAM_DATA_WIDTH-1:0] xfer_tx_data_i,
    output logic [PARAM_DATA_WIDTH-1:0] xfer_rx_data_o,
    output logic                        xfer_busy_o,
    output logic                        xfer_done_o,
    output logic                        clkd_enable_o,
    output logic [PARAM_DIV_W-1:0]      clkd_clk_div_o,
    input  logic                        clkd_time_base_i,
    output logic                        spi_sck_o,
    output logic                        spi_mosi_o,
    input  logic                        spi_miso_i,
    output logic                        spi_ss_n_o
);
    localparam int DW    = PARAM_DATA_WIDTH;
    localparam int CNT_W = clogb2(2 * DW);
    localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DW - 1);

    xfer_state_e          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [1:0]           mode_q;
    logic                 lsb_q;
    logic                 sck_q, mosi_q, ss_n_q, en_q, busy_q, done_q;
    logic [PARAM_DIV_W-1:0] div_q;
    logic [DW-1:0]        rx_q;

    logic          tick, accept, lead_edge, last_edge, shift_tick, drive_bit, sample_bit;
    logic          cpha_q, sr_sout;
    logic [DW-1:0] load_val_d, sr_rx;

    function automatic logic first_bit(input logic [DW-1:0] w, input logic lsb_first);
        return lsb_first ? w[0] : w[DW-1];
    endfunction

    assign cpha_q     = mode_q[MODE_CPHA_BIT];
    assign tick       = en_q & clkd_time_base_i;
    assign accept     = (state_q == ST_IDLE) & xfer_start_i;
    assign lead_edge  = ~cnt_q[0];
    assign last_edge  = (cnt_q == LAST_EDGE);
    assign shift_tick = (state_q == ST_SHIFT) & tick;
    assign drive_bit  = shift_tick & (cpha_q ? lead_edge : (~lead_edge & ~last_edge));
    assign sample_bit = shift_tick & (cpha_q ? ~lead_edge : lead_edge);

    // With CPHA=0 the first bit goes onto MOSI at accept, so the register starts one bit ahead.
    assign load_val_d = xfer_cpha_i ? xfer_tx_data_i
                      : (xfer_lsb_first_i ? (xfer_tx_data_i >> 1) : (xfer_tx_data_i << 1));

    spi_ip_shift_reg #(
        .PARAM_DATA_WIDTH(DW)
    ) u_shift_reg (
        .clk_i      (xfer_clk_i),
        .load_i     (accept),
        .load_val_i (load_val_d),
        .lsb_first_i(lsb_q),
        .shift_i    (drive_bit),
        .sample_i   (sample_bit),
        .sin_i      (spi_miso_i),
        .sout_o     (sr_sout),
        .rx_o       (sr_rx)
    );

    always_ff @(posedge xfer_clk_i) begin
        if (xfer_rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            lsb_q   <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            ss_n_q  <= 1'b1;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            div_q   <= '0;
            rx_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    sck_q <= xfer_cpol_i;
                    if (xfer_start_i) begin
                        mode_q[MODE_CPOL_BIT] <= xfer_cpol_i;
                        mode_q[MODE_CPHA_BIT] <= xfer_cpha_i;
                        lsb_q   <= xfer_lsb_first_i;
                        div_q   <= xfer_clk_div_i;
                        ss_n_q  <= 1'b0;
                        en_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_SETUP;
                        if (!xfer_cpha_i) mosi_q <= first_bit(xfer_tx_data_i, xfer_lsb_first_i);
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        cnt_q   <= '0;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        sck_q <= ~sck_q;
                        cnt_q <= cnt_q + 1'b1;
                        if (drive_bit) mosi_q <= sr_sout;
                        if (last_edge) state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        sck_q   <= mode_q[MODE_CPOL_BIT];
                        ss_n_q  <= 1'b1;
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        en_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        rx_q    <= sr_rx;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign xfer_rx_data_o = rx_q;
    assign xfer_busy_o    = busy_q;
    assign xfer_done_o    = done_q;
    assign clkd_enable_o  = en_q;
    assign clkd_clk_div_o = div_q;
    assign spi_sck_o      = sck_q;
    assign spi_mosi_o     = mosi_q;
    assign spi_ss_n_o     = ss_n_q;

endmodule

// File: tb/tb_spi_ip_xfer_ctrl.sv
// Randomized bench for spi_ip_xfer_ctrl with a divider model, an SPI slave
// model and a word-level reference for timing, bit order and received data.
module tb_spi_ip_xfer_ctrl;
    localparam int DW    = 8;
    localparam int DIV_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, cpol = 1'b0, cpha = 1'b0, lsb = 1'b0;
    logic [DIV_W-1:0] div = '0;
    logic [DW-1:0] tx = '0;
    logic [DW-1:0] rx_o;
    logic busy_o, done_o, en_o, sck_o, mosi_o, ss_n_o, miso, tb_tick;
    logic [DIV_W-1:0] div_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spi_ip_xfer_ctrl #(
        .PARAM_DATA_WIDTH(DW),
        .PARAM_MAX_DIV(8)
    ) dut (
        .xfer_clk_i      (clk),
        .xfer_rst_i      (rst),
        .xfer_start_i    (start),
        .xfer_cpol_i     (cpol),
        .xfer_cpha_i     (cpha),
        .xfer_lsb_first_i(lsb),
        .xfer_clk_div_i  (div),
        .xfer_tx_data_i  (tx),
        .xfer_rx_data_o  (rx_o),
        .xfer_busy_o     (busy_o),
        .xfer_done_o     (done_o),
        .clkd_enable_o   (en_o),
        .clkd_clk_div_o  (div_o),
        .clkd_time_base_i(tb_tick),
        .spi_sck_o       (sck_o),
        .spi_mosi_o      (mosi_o),
        .spi_miso_i      (miso),
        .spi_ss_n_o      (ss_n_o)
    );

    // Divider model: tick every 2^d enabled cycles, restarting whenever disabled.
    logic [7:0] dcnt = '0;
    assign tb_tick = en_o && (dcnt == ((8'd1 << div_o) - 8'd1));
    always @(posedge clk) begin
        if (!en_o || tb_tick) dcnt <= '0;
        else dcnt <= dcnt + 8'd1;
    end

    // Slave model. smode 0: MISO looped from MOSI; 1: shifts out sword; 2: toggles on each rising SCK.
    int m_cpol = 0, m_cpha = 0, m_lsb = 0, smode = 0, sidx = 0;
    logic [DW-1:0] sword = '0;
    logic miso_m = 1'b0, sck_prev = 1'b0, ss_prev = 1'b1;
    assign miso = (smode == 0) ? mosi_o : miso_m;

    function automatic logic wbit(input logic [DW-1:0] w, input int lsbf, input int i);
        return (lsbf != 0) ? w[i] : w[DW-1-i];
    endfunction

    always @(negedge clk) begin
        if (ss_prev && !ss_n_o) begin
            miso_m = (smode == 1 && m_cpha == 0) ? wbit(sword, m_lsb, 0) : 1'b0;
            sidx   = (m_cpha == 0) ? 1 : 0;
        end else if (!ss_prev && !ss_n_o && sck_o != sck_prev) begin
            if (smode == 2) begin
                if (sck_o) miso_m = ~miso_m;
            end else if (smode == 1) begin
                if ((m_cpha == 1 && int'(sck_prev) == m_cpol) || (m_cpha == 0 && int'(sck_prev) != m_cpol)) begin
                    if (sidx < DW) miso_m = wbit(sword, m_lsb, sidx);
                    sidx++;
                end
            end
        end
        sck_prev = sck_o;
        ss_prev  = ss_n_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Word the master should receive, derived from the slave's behaviour.
    function automatic logic [DW-1:0] exp_rx(input int sm, input logic [DW-1:0] t, input logic [DW-1:0] sw,
                                             input int pol, input int pha, input int lsbf);
        logic [DW-1:0] w;
        int e, rises;
        if (sm == 0) return t;
        if (sm == 1) return sw;
        w = '0;
        for (int i = 0; i < DW; i++) begin
            e = (pha != 0) ? 2 * i + 1 : 2 * i;
            rises = (pol == 0) ? (e + 1) / 2 : e / 2;
            if (lsbf != 0) w[i] = logic'(rises % 2);
            else w[DW-1-i] = logic'(rises % 2);
        end
        return w;
    endfunction

    // Called at posedge+1; that cycle is cycle 0 with start high.
    task automatic run_xfer(input logic c_pol, input logic c_pha, input logic c_lsb, input int d,
                            input logic [DW-1:0] t, input int sm, input logic [DW-1:0] sw,
                            input int extra, input int rst_at);
        int exp_done, exp_ss_last, limit, rising, done_cnt, done_cyc, ss_first, ss_last, cap_idx;
        logic p_sck, p_ss, lead;
        logic [DW-1:0] cap, exp_w;
        m_cpol = int'(c_pol); m_cpha = int'(c_pha); m_lsb = int'(c_lsb);
        smode = sm; sword = sw;
        cpol = c_pol; cpha = c_pha; lsb = c_lsb; div = DIV_W'(d); tx = t; start = 1'b1;
        exp_w       = exp_rx(sm, t, sw, int'(c_pol), int'(c_pha), int'(c_lsb));
        exp_done    = (2 * DW + 3) * (1 << d) + 1;
        exp_ss_last = (2 * DW + 2) * (1 << d);
        limit       = (rst_at > 0) ? rst_at + 40 : exp_done + ((extra != 0) ? 30 : 2);
        rising = 0; done_cnt = 0; done_cyc = -1; ss_first = -1; ss_last = -1; cap_idx = 0; cap = '0;
        p_sck = sck_o; p_ss = ss_n_o;
        for (int c = 1; c <= limit; c++) begin
            @(posedge clk); #1;
            start = (extra != 0 && (c == 5 || c == 10)) ? 1'b1 : 1'b0;
            if (c == 2) begin
                tx = DW'($urandom); cpol = 1'($urandom); cpha = 1'($urandom);
                lsb = 1'($urandom); div = DIV_W'($urandom);
            end
            if (c == 1) begin
                check("accept_busy", busy_o, 1);
                check("accept_en", en_o, 1);
                check("accept_div", div_o, d);
            end
            if (rst_at > 0 && c == rst_at) rst = 1'b1;
            if (rst_at > 0 && c == rst_at + 1) begin
                rst = 1'b0;
                check("rst_ss_n", ss_n_o, 1);
                check("rst_sck", sck_o, 0);
                check("rst_en", en_o, 0);
                check("rst_busy", busy_o, 0);
                check("rst_rx", rx_o, 0);
            end
            if (!ss_n_o) begin
                if (ss_first < 0) ss_first = c;
                ss_last = c;
            end
            if (!p_ss && !ss_n_o && sck_o != p_sck) begin
                lead = (p_sck == c_pol);
                if (sck_o) rising++;
                if ((lead && !c_pha) || (!lead && c_pha)) begin
                    if (cap_idx < DW) begin
                        if (c_lsb) cap[cap_idx] = mosi_o;
                        else cap[DW-1-cap_idx] = mosi_o;
                    end
                    cap_idx++;
                end
            end
            if (done_o) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    check("done_rx", rx_o, exp_w);
                    check("done_sck_idle", sck_o, c_pol);
                    check("done_busy", busy_o, 0);
                end
            end
            if (done_cyc >= 0 && c == done_cyc + 1) check("done_width", done_o, 0);
            p_sck = sck_o; p_ss = ss_n_o;
        end
        if (rst_at > 0) begin
            check("rst_no_done", done_cnt, 0);
        end else begin
            check("done_cycle", done_cyc, exp_done);
            check("done_count", done_cnt, 1);
            check("rx_hold", rx_o, exp_w);
            check("mosi_word", cap, t);
            check("sck_rising", rising, DW);
            check("ss_first", ss_first, 1);
            check("ss_last", ss_last, exp_ss_last);
        end
    endtask

    task automatic run_b2b(input logic [DW-1:0] t);
        int last_done, hi_run, n_done;
        logic prev_done, seen_low;
        m_cpol = 0; m_cpha = 0; m_lsb = 0; smode = 0;
        cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; div = '0; tx = t; start = 1'b1;
        last_done = 0; hi_run = 0; n_done = 0; prev_done = 1'b0; seen_low = 1'b0;
        for (int c = 1; c <= 85; c++) begin
            @(posedge clk); #1;
            if (prev_done) check("b2b_done_width", done_o, 0);
            if (done_o) begin
                n_done++;
                check("b2b_period", c - last_done, 20);
                check("b2b_rx", rx_o, t);
                last_done = c;
            end
            if (ss_n_o) begin
                hi_run++;
            end else begin
                if (seen_low && hi_run > 0) check("b2b_ss_high_ge2", (hi_run >= 2) ? 1 : 0, 1);
                hi_run = 0;
                seen_low = 1'b1;
            end
            prev_done = done_o;
        end
        start = 1'b0;
        check("b2b_done_count", n_done, 4);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_ss_n", ss_n_o, 1);
        check("reset_sck", sck_o, 0);
        check("reset_mosi", mosi_o, 0);
        check("reset_en", en_o, 0);
        check("reset_div", div_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_rx", rx_o, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_xfer(1'b0, 1'b0, 1'b0, 0, 8'hA5, 0, 8'h00, 0, 0);
        run_xfer(1'b0, 1'b0, 1'b0, 1, 8'h4E, 0, 8'h00, 0, 0);
        run_xfer(1'b1, 1'b1, 1'b1, 2, 8'h3C, 1, 8'h81, 0, 0);
        run_xfer(1'b0, 1'b0, 1'b0, 0, 8'h5A, 0, 8'h00, 1, 0);
        run_xfer(1'b0, 1'b0, 1'b0, 0, 8'hC3, 0, 8'h00, 0, 9);
        run_xfer(1'b0, 1'b0, 1'b0, 0, 8'h96, 0, 8'h00, 0, 0);
        run_xfer(1'b0, 1'b0, 1'b0, 0, 8'h0F, 2, 8'h00, 0, 0);
        run_xfer(1'b0, 1'b1, 1'b0, 0, 8'hF0, 2, 8'h00, 0, 0);
        for (int i = 0; i < 10; i++) begin
            run_xfer(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                     DW'($urandom), int'($urandom_range(0, 2)), DW'($urandom), 0, 0);
        end
        run_b2b(8'h69);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
